alu_uart_ctrl: RTL
==================

ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

Interface
REQ-001 Parameter BUS_SIZE, default 8, SHALL set the operand/result width; byte-serial transfer SHALL require BUS_SIZE = 8.
REQ-002 Parameter OP_SIZE, default 6, SHALL set the ALU operation-code width.
REQ-003 i_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 i_reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 i_rx_data  input  8  SHALL be the received UART byte, valid only while i_rx_done = 1.
REQ-006 i_rx_done  input  1  SHALL be the one-cycle pulse marking a received byte.
REQ-007 i_tx_done  input  1  SHALL be the one-cycle pulse marking completion of a transmitted byte.
REQ-008 i_alu_result  input  BUS_SIZE  SHALL be the combinational ALU output.
REQ-009 o_alu_data_1  output  BUS_SIZE  SHALL be the registered first ALU operand.
REQ-010 o_alu_data_2  output  BUS_SIZE  SHALL be the registered second ALU operand.
REQ-011 o_alu_ctrl  output  OP_SIZE  SHALL be the registered ALU operation code.
REQ-012 o_tx_data  output  8  SHALL be the registered byte to transmit.
REQ-013 o_tx_start  output  1  SHALL be the one-cycle transmit request.
REQ-014 o_busy  output  1  SHALL be 1 in every state except WAIT_A.

Function
REQ-015 FSM states SHALL be WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
REQ-016 WAIT_A on i_rx_done SHALL load o_alu_data_1 from i_rx_data and go to WAIT_B.
REQ-017 WAIT_B on i_rx_done SHALL load o_alu_data_2 from i_rx_data and go to WAIT_OP.
REQ-018 WAIT_OP on i_rx_done SHALL load o_alu_ctrl from i_rx_data[OP_SIZE-1:0] and go to EXEC; bits above OP_SIZE-1 SHALL be ignored.
REQ-019 EXEC SHALL last exactly one cycle, capture i_alu_result into o_tx_data at its end, and go to SEND.
REQ-020 SEND SHALL assert o_tx_start for exactly one cycle and go to WAIT_TX.
REQ-021 WAIT_TX SHALL hold until i_tx_done = 1, then go to WAIT_A.
REQ-022 Latency: opcode i_rx_done in cycle N SHALL give o_tx_start = 1 in cycle N+2.
REQ-023 i_rx_done in EXEC, SEND or WAIT_TX SHALL be ignored (byte dropped, no state change).
REQ-024 i_tx_done outside WAIT_TX SHALL be ignored.
REQ-025 Operand and opcode registers SHALL hold their values until overwritten by the next transaction.
REQ-026 o_tx_start SHALL never be asserted on two consecutive cycles.

Reset
REQ-027 i_reset = 1 SHALL force state WAIT_A and clear o_alu_data_1, o_alu_data_2, o_alu_ctrl and o_tx_data to 0, o_tx_start to 0, and o_busy to 0 on the next edge.
REQ-028 Reset SHALL take priority over i_rx_data, i_rx_done and i_tx_done in the same cycle.
REQ-029 Reset in any state (mid-transaction) SHALL discard the partial transaction; no o_tx_start SHALL follow.

Configuration
REQ-030 Macro ALU_CTRL_OPCODE_CHECK_EN, when defined, SHALL validate the opcode in WAIT_OP against {0x02, 0x03, 0x20, 0x22, 0x24, 0x25, 0x26, 0x27}.
REQ-031 With ALU_CTRL_OPCODE_CHECK_EN defined, an invalid opcode SHALL leave o_alu_ctrl unchanged, load o_tx_data with 0xEE, and go directly to SEND.
REQ-032 Without ALU_CTRL_OPCODE_CHECK_EN, every opcode SHALL be passed to the ALU and its result transmitted per REQ-019.

Verification
REQ-033 Bytes 0x05, 0x03, 0x20, then i_tx_done -> o_tx_data = 0x08 and one o_tx_start pulse two cycles after the opcode pulse; FSM returns to WAIT_A, o_busy = 0.
REQ-034 Bytes 0x03, 0x05, 0x22 -> o_tx_data = 0xFE.
REQ-035 Bytes 0xF0, 0x0F, 0x27, with an extra i_rx_done = 0xAA during WAIT_TX -> o_tx_data = 0x00; 0xAA is dropped; the next transaction starts clean at WAIT_A.
REQ-036 i_reset after two bytes, then bytes 0x01, 0x01, 0x20 -> o_tx_start never pulses before the post-reset opcode; o_tx_data = 0x02.
REQ-037 i_reset = 1 and i_rx_done = 1 in the same cycle -> state WAIT_A, o_alu_data_1 = 0.
REQ-038 With ALU_CTRL_OPCODE_CHECK_EN defined, bytes 0x01, 0x02, 0x3F -> o_tx_data = 0xEE, o_tx_start pulses one cycle after the opcode pulse; without the macro -> o_tx_data = ALU default output.

Source files
------------

// File: rtl/alu_uart_ctrl.sv
// rtl/alu_uart_ctrl.sv - UART byte sequencer for an ALU: operand A, operand B, opcode in; result byte out.
// Optional opcode screening when ALU_CTRL_OPCODE_CHECK_EN is defined (invalid opcodes answer 0xEE).
module alu_uart_ctrl #(
    parameter int BUS_SIZE = 8,
    parameter int OP_SIZE  = 6
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_done,
    input  logic                i_tx_done,
    input  logic [BUS_SIZE-1:0] i_alu_result,
    output logic [BUS_SIZE-1:0] o_alu_data_1,
    output logic [BUS_SIZE-1:0] o_alu_data_2,
    output logic [OP_SIZE-1:0]  o_alu_ctrl,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_start,
    output logic                o_busy
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t state;

`ifdef ALU_CTRL_OPCODE_CHECK_EN
    function automatic logic opcode_valid(input logic [OP_SIZE-1:0] op);
        logic [7:0] ext;
        ext = 8'(op);
        case (ext)
            8'h02, 8'h03, 8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= WAIT_A;
            o_alu_data_1 <= '0;
            o_alu_data_2 <= '0;
            o_alu_ctrl   <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_alu_data_1 <= BUS_SIZE'(i_rx_data);
                        o_busy       <= 1'b1;
                        state        <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) begin
                        o_alu_data_2 <= BUS_SIZE'(i_rx_data);
                        state        <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
`ifdef ALU_CTRL_OPCODE_CHECK_EN
                        if (opcode_valid(i_rx_data[OP_SIZE-1:0])) begin
                            o_alu_ctrl <= i_rx_data[OP_SIZE-1:0];
                            state      <= EXEC;
                        end else begin
                            // Skip the ALU entirely and report the bad opcode.
                            o_tx_data  <= 8'hEE;
                            o_tx_start <= 1'b1;
                            state      <= SEND;
                        end
`else
                        o_alu_ctrl <= i_rx_data[OP_SIZE-1:0];
                        state      <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    // ALU has seen the registered operands/opcode for a full cycle.
                    o_tx_data  <= 8'(i_alu_result);
                    o_tx_start <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        o_busy <= 1'b0;
                        state  <= WAIT_A;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= WAIT_A;
                end
            endcase
        end
    end

endmodule
